// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch front end: FSM encoding,
// queue entry layout and the default reset PC.
package fetch_pkg;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    GAP  = 2'd1,
    FULL = 2'd2
  } fetchState_t;

  // Queue entry is {pc, instr}
  localparam int ENTRY_WIDTH = 64;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  function automatic logic [31:0] alignWord(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/instr_queue.sv
// Circular-buffer FIFO holding fetched {pc, instr} entries in program order.
// Flush wins over push/pop; a push while full only succeeds alongside a pop.
module instr_queue #(
  parameter int WIDTH     = 64,
  parameter int ADDR_BITS = 3
) (
  input  logic                 clkIn,
  input  logic                 resetIn,
  input  logic                 enable,
  input  logic                 flush,
  input  logic                 push,
  input  logic [WIDTH-1:0]     pushData,
  input  logic                 pop,
  output logic [ADDR_BITS:0]   count,
  output logic                 headValid,
  output logic [WIDTH-1:0]     headData
);

  localparam int DEPTH = 1 << ADDR_BITS;
  localparam logic [ADDR_BITS:0]   FULL_COUNT = (ADDR_BITS + 1)'(DEPTH);
  localparam logic [ADDR_BITS:0]   ONE_COUNT  = (ADDR_BITS + 1)'(1);
  localparam logic [ADDR_BITS-1:0] ONE_PTR    = ADDR_BITS'(1);

  logic [WIDTH-1:0]     mem [DEPTH];
  logic [ADDR_BITS-1:0] headPtr;
  logic [ADDR_BITS-1:0] tailPtr;
  logic                 doPush;
  logic                 doPop;

  assign headValid = (count != '0);
  assign doPop     = pop && headValid;
  assign doPush    = push && ((count != FULL_COUNT) || doPop);
  assign headData  = headValid ? mem[headPtr] : '0;

  always_ff @(posedge clkIn) begin
    if (!resetIn) begin
      headPtr <= '0;
      tailPtr <= '0;
      count   <= '0;
    end else if (enable) begin
      if (flush) begin
        headPtr <= '0;
        tailPtr <= '0;
        count   <= '0;
      end else begin
        if (doPush) tailPtr <= tailPtr + ONE_PTR;
        if (doPop)  headPtr <= headPtr + ONE_PTR;
        case ({doPush, doPop})
          2'b10:   count <= count + ONE_COUNT;
          2'b01:   count <= count - ONE_COUNT;
          default: count <= count;
        endcase
      end
    end
  end

  // Storage carries no reset; validity is tracked by count alone
  always_ff @(posedge clkIn) begin
    if (enable && !flush && doPush) begin
      mem[tailPtr] <= pushData;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch front end: owns the PC, issues one request at a time to the cache
// and queues each returned instruction with its PC for the decode stage.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int          ADDR_WIDTH  = 17,
  parameter int          QUEUE_WIDTH = 3,
  parameter logic [31:0] RESET_PC    = DEFAULT_RESET_PC
) (
  input  logic                  clkIn,
  input  logic                  resetIn,
  input  logic                  readyIn,
  output logic                  instrInValid,
  output logic [ADDR_WIDTH-1:0] instrAddrIn,
  input  logic                  instrOutValid,
  input  logic [31:0]           instrOut,
  input  logic                  jumpValid,
  input  logic [31:0]           jumpAddr,
  output logic                  queueOutValid,
  input  logic                  queueOutReady,
  output logic [31:0]           queueOutInstr,
  output logic [31:0]           queueOutPc
);

  localparam logic [QUEUE_WIDTH:0] QUEUE_DEPTH = (QUEUE_WIDTH + 1)'(1 << QUEUE_WIDTH);

  fetchState_t            state;
  fetchState_t            stateNext;
  logic [31:0]            pc;
  logic [31:0]            pcNext;
  logic [31:0]            jumpTarget;
  logic [QUEUE_WIDTH:0]   count;
  logic [QUEUE_WIDTH:0]   countAfter;
  logic                   pushFire;
  logic                   popFire;
  logic [ENTRY_WIDTH-1:0] headData;

  assign jumpTarget = alignWord(jumpAddr);
  assign pushFire   = (state == REQ) && instrOutValid;
  assign popFire    = queueOutValid && queueOutReady;
  assign countAfter = count + (QUEUE_WIDTH + 1)'(pushFire) - (QUEUE_WIDTH + 1)'(popFire);

  instr_queue #(
    .WIDTH     (ENTRY_WIDTH),
    .ADDR_BITS (QUEUE_WIDTH)
  ) queueInst (
    .clkIn     (clkIn),
    .resetIn   (resetIn),
    .enable    (readyIn),
    .flush     (jumpValid),
    .push      (pushFire && !jumpValid),
    .pushData  ({pc, instrOut}),
    .pop       (queueOutReady),
    .count     (count),
    .headValid (queueOutValid),
    .headData  (headData)
  );

  assign queueOutPc    = headData[ENTRY_WIDTH-1:32];
  assign queueOutInstr = headData[31:0];

  // A redirect overrides whatever the FSM was doing, including a same-cycle response
  always_comb begin
    stateNext = state;
    pcNext    = pc;
    if (jumpValid) begin
      stateNext = GAP;
      pcNext    = jumpTarget;
    end else begin
      case (state)
        REQ: begin
          if (instrOutValid) begin
            pcNext    = pc + 32'd4;
            stateNext = GAP;
          end
        end
        GAP:     stateNext = (countAfter < QUEUE_DEPTH) ? REQ : FULL;
        FULL:    if (popFire) stateNext = REQ;
        default: stateNext = GAP;
      endcase
    end
  end

  // Request outputs are registered from the next state so they line up with the FSM
  always_ff @(posedge clkIn) begin
    if (!resetIn) begin
      state        <= GAP;
      pc           <= RESET_PC;
      instrInValid <= 1'b0;
      instrAddrIn  <= '0;
    end else if (readyIn) begin
      state        <= stateNext;
      pc           <= pcNext;
      instrInValid <= (stateNext == REQ);
      instrAddrIn  <= pcNext[ADDR_WIDTH-1:0];
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: a directed vector table, hand-written
// corner sequences and a randomized run checked against a queue-based reference model.
module tb_instr_fetch_unit;

  localparam int          ADDR_WIDTH  = 17;
  localparam int          QUEUE_WIDTH = 3;
  localparam logic [31:0] RESET_PC    = 32'h0;

  logic                  clkIn = 1'b0;
  logic                  resetIn = 1'b0;
  logic                  readyIn = 1'b1;
  logic                  instrInValid;
  logic [ADDR_WIDTH-1:0] instrAddrIn;
  logic                  instrOutValid = 1'b0;
  logic [31:0]           instrOut = 32'h0;
  logic                  jumpValid = 1'b0;
  logic [31:0]           jumpAddr = 32'h0;
  logic                  queueOutValid;
  logic                  queueOutReady = 1'b0;
  logic [31:0]           queueOutInstr;
  logic [31:0]           queueOutPc;

  instr_fetch_unit #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .QUEUE_WIDTH (QUEUE_WIDTH),
    .RESET_PC    (RESET_PC)
  ) dut (
    .clkIn         (clkIn),
    .resetIn       (resetIn),
    .readyIn       (readyIn),
    .instrInValid  (instrInValid),
    .instrAddrIn   (instrAddrIn),
    .instrOutValid (instrOutValid),
    .instrOut      (instrOut),
    .jumpValid     (jumpValid),
    .jumpAddr      (jumpAddr),
    .queueOutValid (queueOutValid),
    .queueOutReady (queueOutReady),
    .queueOutInstr (queueOutInstr),
    .queueOutPc    (queueOutPc)
  );

  always #5 clkIn = ~clkIn;

  typedef struct {
    logic        rst;
    logic        rdy;
    logic        ov;
    logic [31:0] instr;
    logic        jv;
    logic [31:0] jaddr;
    logic        qrdy;
  } stim_t;

  typedef struct {
    stim_t       s;
    logic        expIv;
    logic [16:0] expAddr;
    logic        expQv;
    logic [31:0] expPc;
    logic [31:0] expInstr;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  int checks = 0;
  int errors = 0;

  // Reference model: program-order list of fetched words plus a few flags
  entry_t      mQ[$];
  logic [31:0] mPc = RESET_PC;
  logic [16:0] mAddr = '0;
  bit          mReq = 0;
  bit          mCool = 1;
  bit          mWait = 0;

  function automatic stim_t mkStim(logic rst, logic rdy, logic ov, logic [31:0] instr,
                                   logic jv, logic [31:0] jaddr, logic qrdy);
    stim_t s;
    s.rst = rst; s.rdy = rdy; s.ov = ov; s.instr = instr;
    s.jv = jv; s.jaddr = jaddr; s.qrdy = qrdy;
    return s;
  endfunction

  function automatic vec_t mkVec(logic rst, logic ov, logic [31:0] instr, logic qrdy,
                                 logic eIv, logic [16:0] eAddr, logic eQv,
                                 logic [31:0] ePc, logic [31:0] eInstr);
    vec_t v;
    v.s = mkStim(rst, 1'b1, ov, instr, 1'b0, 32'h0, qrdy);
    v.expIv = eIv; v.expAddr = eAddr; v.expQv = eQv;
    v.expPc = ePc; v.expInstr = eInstr;
    return v;
  endfunction

  task automatic modelStep(input stim_t s);
    entry_t e;
    bit popNow;
    if (!s.rst) begin
      mPc = RESET_PC; mQ.delete(); mReq = 0; mCool = 1; mWait = 0; mAddr = '0;
      return;
    end
    if (!s.rdy) return;
    if (s.jv) begin
      mPc = s.jaddr & 32'hFFFF_FFFC; mQ.delete(); mReq = 0; mCool = 1; mWait = 0;
    end else begin
      popNow = (mQ.size() != 0) && s.qrdy;
      if (popNow) void'(mQ.pop_front());
      if (mReq && s.ov) begin
        e.pc = mPc; e.instr = s.instr;
        mQ.push_back(e);
        mPc = mPc + 32'd4; mReq = 0; mCool = 1;
      end else if (mCool) begin
        mCool = 0;
        if (mQ.size() < 8) mReq = 1; else mWait = 1;
      end else if (mWait && popNow) begin
        mWait = 0; mReq = 1;
      end
    end
    mAddr = mPc[16:0];
  endtask

  task automatic applyStimulus(input stim_t s);
    resetIn = s.rst; readyIn = s.rdy; instrOutValid = s.ov; instrOut = s.instr;
    jumpValid = s.jv; jumpAddr = s.jaddr; queueOutReady = s.qrdy;
    @(posedge clkIn);
    modelStep(s);
    @(negedge clkIn);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic checkAgainstModel(input string tag);
    logic [31:0] ePc;
    logic [31:0] eInstr;
    ePc = 32'h0; eInstr = 32'h0;
    if (mQ.size() != 0) begin
      ePc = mQ[0].pc; eInstr = mQ[0].instr;
    end
    checkOutput({tag, ".instrInValid"}, {31'b0, instrInValid}, {31'b0, mReq});
    checkOutput({tag, ".instrAddrIn"}, {15'b0, instrAddrIn}, {15'b0, mAddr});
    checkOutput({tag, ".queueOutValid"}, {31'b0, queueOutValid}, {31'b0, (mQ.size() != 0)});
    checkOutput({tag, ".queueOutPc"}, queueOutPc, ePc);
    checkOutput({tag, ".queueOutInstr"}, queueOutInstr, eInstr);
  endtask

  task automatic step(input logic rst, input logic rdy, input logic ov, input logic [31:0] instr,
                      input logic jv, input logic [31:0] jaddr, input logic qrdy);
    applyStimulus(mkStim(rst, rdy, ov, instr, jv, jaddr, qrdy));
    checkAgainstModel("seq");
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t tbl[9];
    stim_t rs;

    // Reset, first request, a hit, a stale valid in GAP, a second hit, then drain
    tbl[0] = mkVec(0, 0, 32'h0,         0, 0, 17'h0, 0, 32'h0, 32'h0);
    tbl[1] = mkVec(0, 0, 32'h0,         0, 0, 17'h0, 0, 32'h0, 32'h0);
    tbl[2] = mkVec(1, 0, 32'h0,         0, 1, 17'h0, 0, 32'h0, 32'h0);
    tbl[3] = mkVec(1, 0, 32'h0,         0, 1, 17'h0, 0, 32'h0, 32'h0);
    tbl[4] = mkVec(1, 1, 32'hA000_0000, 0, 0, 17'h4, 1, 32'h0, 32'hA000_0000);
    tbl[5] = mkVec(1, 1, 32'hDEAD_BEEF, 0, 1, 17'h4, 1, 32'h0, 32'hA000_0000);
    tbl[6] = mkVec(1, 1, 32'hB000_0004, 0, 0, 17'h8, 1, 32'h0, 32'hA000_0000);
    tbl[7] = mkVec(1, 0, 32'h0,         1, 1, 17'h8, 1, 32'h4, 32'hB000_0004);
    tbl[8] = mkVec(1, 0, 32'h0,         1, 1, 17'h8, 0, 32'h0, 32'h0);

    @(negedge clkIn);
    for (int i = 0; i < 9; i++) begin
      applyStimulus(tbl[i].s);
      checkOutput($sformatf("vec%0d.instrInValid", i), {31'b0, instrInValid}, {31'b0, tbl[i].expIv});
      checkOutput($sformatf("vec%0d.instrAddrIn", i), {15'b0, instrAddrIn}, {15'b0, tbl[i].expAddr});
      checkOutput($sformatf("vec%0d.queueOutValid", i), {31'b0, queueOutValid}, {31'b0, tbl[i].expQv});
      checkOutput($sformatf("vec%0d.queueOutPc", i), queueOutPc, tbl[i].expPc);
      checkOutput($sformatf("vec%0d.queueOutInstr", i), queueOutInstr, tbl[i].expInstr);
    end

    // Fill to full with responses always offered and no consumer
    step(0, 1, 0, 32'h0, 0, 32'h0, 0);
    step(0, 1, 0, 32'h0, 0, 32'h0, 0);
    for (int i = 0; i < 20; i++) step(1, 1, 1, 32'h1234_0000 + i, 0, 32'h0, 0);
    checkOutput("fullNoReq", {31'b0, instrInValid}, 32'h0);
    checkOutput("fullHeadPc", queueOutPc, 32'h0);
    step(1, 1, 1, 32'h5555_0000, 0, 32'h0, 0);
    checkOutput("fullStillIdle", {31'b0, instrInValid}, 32'h0);

    // Single pop reopens fetching at 0x20; refill to 8 and drain in order
    step(1, 1, 0, 32'h0, 0, 32'h0, 1);
    checkOutput("reqAfterPop.valid", {31'b0, instrInValid}, 32'h1);
    checkOutput("reqAfterPop.addr", {15'b0, instrAddrIn}, 32'h20);
    step(1, 1, 1, 32'hCAFE_0020, 0, 32'h0, 0);
    step(1, 1, 0, 32'h0, 0, 32'h0, 0);
    checkOutput("refullNoReq", {31'b0, instrInValid}, 32'h0);
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("drain%0d.pc", i), queueOutPc, 32'h4 + 32'(4 * i));
      step(1, 1, 0, 32'h0, 0, 32'h0, 1);
    end
    checkOutput("drainedEmpty", {31'b0, queueOutValid}, 32'h0);

    // Response and pop in the same cycle
    step(1, 1, 1, 32'h0000_0024, 0, 32'h0, 0);
    step(1, 1, 0, 32'h0, 0, 32'h0, 0);
    step(1, 1, 1, 32'h0000_0028, 0, 32'h0, 1);
    checkOutput("pushPop.headPc", queueOutPc, 32'h28);

    // Redirect coinciding with a response
    step(1, 1, 0, 32'h0, 0, 32'h0, 0);
    step(1, 1, 1, 32'h7777_7777, 1, 32'h1003, 0);
    checkOutput("jumpFlush", {31'b0, queueOutValid}, 32'h0);
    checkOutput("jumpNoReq", {31'b0, instrInValid}, 32'h0);
    step(1, 1, 0, 32'h0, 0, 32'h0, 0);
    checkOutput("jumpReq.valid", {31'b0, instrInValid}, 32'h1);
    checkOutput("jumpReq.addr", {15'b0, instrAddrIn}, 32'h1000);

    // readyIn stall mid-miss with a willing consumer
    step(1, 1, 1, 32'h0000_1000, 0, 32'h0, 0);
    step(1, 1, 0, 32'h0, 0, 32'h0, 0);
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 1, 32'h9999_0000, 0, 32'h0, 1);
      checkOutput("stall.headPc", queueOutPc, 32'h1000);
      checkOutput("stall.addr", {15'b0, instrAddrIn}, 32'h1004);
    end
    step(1, 1, 1, 32'h0000_1004, 0, 32'h0, 0);
    checkOutput("resume.addr", {15'b0, instrAddrIn}, 32'h1008);
    checkOutput("resume.headPc", queueOutPc, 32'h1000);

    // Reset with three queued entries and a request outstanding
    step(1, 1, 0, 32'h0, 0, 32'h0, 0);
    step(1, 1, 1, 32'h0000_1008, 0, 32'h0, 0);
    step(1, 1, 0, 32'h0, 0, 32'h0, 0);
    checkOutput("preReset.valid", {31'b0, instrInValid}, 32'h1);
    step(0, 1, 1, 32'h1111_1111, 0, 32'h0, 1);
    checkOutput("midReset.instrInValid", {31'b0, instrInValid}, 32'h0);
    checkOutput("midReset.instrAddrIn", {15'b0, instrAddrIn}, 32'h0);
    checkOutput("midReset.queueOutValid", {31'b0, queueOutValid}, 32'h0);
    checkOutput("midReset.queueOutPc", queueOutPc, 32'h0);
    checkOutput("midReset.queueOutInstr", queueOutInstr, 32'h0);
    step(1, 1, 0, 32'h0, 0, 32'h0, 0);
    checkOutput("restart.addr", {15'b0, instrAddrIn}, RESET_PC);
    checkOutput("restart.valid", {31'b0, instrInValid}, 32'h1);

    // Randomized traffic against the reference model
    for (int i = 0; i < 3000; i++) begin
      rs = mkStim(($urandom_range(0, 199) != 0),
                  ($urandom_range(0, 99) < 85),
                  ($urandom_range(0, 99) < 50),
                  $urandom(),
                  ($urandom_range(0, 99) < 4),
                  $urandom(),
                  ($urandom_range(0, 99) < 45));
      applyStimulus(rs);
      checkAgainstModel("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
